// File: rtl/cache_refill_ctrl_if.sv
// Purpose: bundles the refill request, memory fetch and tag/data SRAM write ports of cache_refill_ctrl.
// Ports: master = request/memory side (drives *_i), slave = refill controller (drives *_o).
// Widths follow the controller parameters; data_addr is {set index, word offset}.
interface cache_refill_ctrl_if #(
    parameter int NUM_WAYS            = 2,
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int CLINE_SIZE_WORD     = 4,
    parameter int CLINE_ADDR_WIDTH    = 7,
    parameter int TAG_SRAM_DATA_WIDTH = 32
);
    localparam int DADDR_WIDTH = CLINE_ADDR_WIDTH + $clog2(CLINE_SIZE_WORD);

    // refill request from the lookup stage
    logic                           req_valid_i;
    logic                           req_ready_o;
    logic [ADDR_WIDTH-1:0]          req_addr_i;
    logic [NUM_WAYS-1:0]            req_way_miss_i;
    logic [NUM_WAYS-1:0]            req_way_valid_i;
    // line fetch towards memory
    logic                           mem_req_valid_o;
    logic                           mem_req_ready_i;
    logic [ADDR_WIDTH-1:0]          mem_req_addr_o;
    logic                           mem_rsp_valid_i;
    logic [DATA_WIDTH-1:0]          mem_rsp_data_i;
    // SRAM write ports
    logic [NUM_WAYS-1:0]            data_we_o;
    logic [DADDR_WIDTH-1:0]         data_addr_o;
    logic [DATA_WIDTH-1:0]          data_wdata_o;
    logic [NUM_WAYS-1:0]            tag_we_o;
    logic [CLINE_ADDR_WIDTH-1:0]    tag_addr_o;
    logic [TAG_SRAM_DATA_WIDTH-1:0] tag_wdata_o;
    // status
    logic                           busy_o;
    logic                           done_o;

    modport master (
        output req_valid_i, req_addr_i, req_way_miss_i, req_way_valid_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  req_ready_o, mem_req_valid_o, mem_req_addr_o,
               data_we_o, data_addr_o, data_wdata_o,
               tag_we_o, tag_addr_o, tag_wdata_o, busy_o, done_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_way_miss_i, req_way_valid_i,
               mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
        output req_ready_o, mem_req_valid_o, mem_req_addr_o,
               data_we_o, data_addr_o, data_wdata_o,
               tag_we_o, tag_addr_o, tag_wdata_o, busy_o, done_o
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Purpose: cache miss refill - picks a victim way, fetches the line, writes data SRAM words, then commits the valid tag.
// Latency: accept N -> mem_req_valid_o N+1 (N+2 with CACHE_REFILL_TAG_INVAL_EN); done_o at N+2+CLINE_SIZE_WORD with no stalls.
// Backpressure: req_ready_o only in IDLE; fetch address held until mem_req_ready_i; FILL waits for mem_rsp_valid_i.
// Ports: clk_i, rst_i (sync, active high), bus (cache_refill_ctrl_if.slave).
// Optional macro CACHE_REFILL_TAG_INVAL_EN: invalidates the victim tag before fetching so a partial line can never hit.
module cache_refill_ctrl #(
    parameter int NUM_WAYS            = 2,
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int CLINE_SIZE_WORD     = 4,
    parameter int CLINE_ADDR_WIDTH    = 7,
    parameter int TAG_SRAM_DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cache_refill_ctrl_if.slave   bus
);
    localparam int WORD_W     = $clog2(CLINE_SIZE_WORD);
    localparam int TAG_OFFSET = WORD_W + CLINE_ADDR_WIDTH;
    localparam int TAG_WIDTH  = ADDR_WIDTH - TAG_OFFSET;
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

`ifdef CACHE_REFILL_TAG_INVAL_EN
    typedef enum logic [2:0] {S_IDLE, S_HITDONE, S_INVAL, S_MREQ, S_FILL, S_TAG} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HITDONE, S_MREQ, S_FILL, S_TAG} state_t;
`endif

    state_t                      r_state;
    state_t                      w_next;
    logic [CLINE_ADDR_WIDTH-1:0] r_idx;
    logic [TAG_WIDTH-1:0]        r_tag;
    logic [WAY_W-1:0]            r_victim;
    logic                        r_evict;   // victim held a valid line -> advance rr on completion
    logic [WAY_W-1:0]            r_rr;
    logic [WORD_W-1:0]           r_cnt;

    logic [WAY_W-1:0]            w_victim;
    logic [NUM_WAYS-1:0]         w_victim_oh;
    logic                        w_accept;
    logic                        w_hit;
    logic                        w_last;
    logic [WAY_W-1:0]            w_rr_next;
    logic [TAG_SRAM_DATA_WIDTH-1:0] w_tag_entry;
    logic                        w_unused;

    // word offset bits of the miss address are implied by the line-aligned fetch
    assign w_unused    = &{1'b0, bus.req_addr_i[WORD_W-1:0]};

    assign w_accept    = bus.req_valid_i && (r_state == S_IDLE);
    assign w_hit       = ~&bus.req_way_miss_i;
    assign w_last      = (r_cnt == WORD_W'(CLINE_SIZE_WORD - 1));
    assign w_victim_oh = NUM_WAYS'(1) << r_victim;
    assign w_rr_next   = (r_rr == WAY_W'(NUM_WAYS - 1)) ? '0 : r_rr + WAY_W'(1);

    // lowest-index invalid way wins; with every way valid fall back to round robin
    always_comb begin
        w_victim = r_rr;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!bus.req_way_valid_i[i]) w_victim = WAY_W'(i);
        end
    end

    always_comb begin
        w_tag_entry                          = '0;
        w_tag_entry[TAG_SRAM_DATA_WIDTH-1]   = 1'b1;
        w_tag_entry[TAG_WIDTH-1:0]           = r_tag;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_tag    <= '0;
            r_victim <= '0;
            r_evict  <= 1'b0;
            r_rr     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx    <= bus.req_addr_i[TAG_OFFSET-1 -: CLINE_ADDR_WIDTH];
                r_tag    <= bus.req_addr_i[ADDR_WIDTH-1:TAG_OFFSET];
                r_victim <= w_victim;
                r_evict  <= &bus.req_way_valid_i;
            end
            if (r_state == S_FILL && bus.mem_rsp_valid_i) begin
                r_cnt <= w_last ? '0 : r_cnt + WORD_W'(1);
            end
            if (r_state == S_TAG && r_evict) begin
                r_rr <= w_rr_next;
            end
        end
    end

    always_comb begin
        w_next              = r_state;
        bus.req_ready_o     = 1'b0;
        bus.mem_req_valid_o = 1'b0;
        bus.mem_req_addr_o  = '0;
        bus.data_we_o       = '0;
        bus.data_addr_o     = '0;
        bus.data_wdata_o    = '0;
        bus.tag_we_o        = '0;
        bus.tag_addr_o      = '0;
        bus.tag_wdata_o     = '0;
        bus.busy_o          = (r_state != S_IDLE);
        bus.done_o          = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
`ifdef CACHE_REFILL_TAG_INVAL_EN
                    w_next = w_hit ? S_HITDONE : S_INVAL;
`else
                    w_next = w_hit ? S_HITDONE : S_MREQ;
`endif
                end
            end
            S_HITDONE: begin
                bus.done_o = 1'b1;
                w_next     = S_IDLE;
            end
`ifdef CACHE_REFILL_TAG_INVAL_EN
            S_INVAL: begin
                // all-zero entry clears the valid bit while the line is being overwritten
                bus.tag_we_o   = w_victim_oh;
                bus.tag_addr_o = r_idx;
                w_next         = S_MREQ;
            end
`endif
            S_MREQ: begin
                bus.mem_req_valid_o = 1'b1;
                bus.mem_req_addr_o  = {r_tag, r_idx, {WORD_W{1'b0}}};
                if (bus.mem_req_ready_i) w_next = S_FILL;
            end
            S_FILL: begin
                if (bus.mem_rsp_valid_i) begin
                    bus.data_we_o    = w_victim_oh;
                    bus.data_addr_o  = {r_idx, r_cnt};
                    bus.data_wdata_o = bus.mem_rsp_data_i;
                    if (w_last) w_next = S_TAG;
                end
            end
            S_TAG: begin
                bus.tag_we_o    = w_victim_oh;
                bus.tag_addr_o  = r_idx;
                bus.tag_wdata_o = w_tag_entry;
                bus.done_o      = 1'b1;
                w_next          = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_refill_ctrl_if #(.NUM_WAYS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .CLINE_SIZE_WORD(4),
                           .CLINE_ADDR_WIDTH(7), .TAG_SRAM_DATA_WIDTH(32)) bus ();

    cache_refill_ctrl #(.NUM_WAYS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .CLINE_SIZE_WORD(4),
                        .CLINE_ADDR_WIDTH(7), .TAG_SRAM_DATA_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [95:0] name;
        // inputs
        logic        rst;
        logic        rv;
        logic [31:0] addr;
        logic [1:0]  miss;
        logic [1:0]  wvld;
        logic        mrdy;
        logic        rspv;
        logic [31:0] rspd;
        // expected outputs
        logic        e_rdy;
        logic        e_mv;
        logic [31:0] e_maddr;
        logic [1:0]  e_dwe;
        logic [8:0]  e_daddr;
        logic [31:0] e_dwd;
        logic [1:0]  e_twe;
        logic [6:0]  e_taddr;
        logic [31:0] e_twd;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // idle cycle: no request, idle outputs expected
    function automatic vec_t nv(input logic [95:0] nm);
        vec_t v;
        v.name = nm;  v.rst = 1'b0; v.rv = 1'b0; v.addr = '0; v.miss = 2'b11; v.wvld = 2'b00;
        v.mrdy = 1'b0; v.rspv = 1'b0; v.rspd = '0;
        v.e_rdy = 1'b1; v.e_mv = 1'b0; v.e_maddr = '0; v.e_dwe = '0; v.e_daddr = '0; v.e_dwd = '0;
        v.e_twe = '0; v.e_taddr = '0; v.e_twd = '0; v.e_busy = 1'b0; v.e_done = 1'b0;
        return v;
    endfunction

    // busy cycle with nothing else expected
    function automatic vec_t bv(input logic [95:0] nm);
        vec_t v = nv(nm);
        v.e_rdy = 1'b0; v.e_busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t req_v(input logic [95:0] nm, input logic [31:0] a, input logic [1:0] miss,
                                   input logic [1:0] wvld);
        vec_t v = nv(nm);
        v.rv = 1'b1; v.addr = a; v.miss = miss; v.wvld = wvld;
        return v;
    endfunction

    function automatic vec_t mreq_v(input logic [95:0] nm, input logic rdy, input logic [31:0] ma);
        vec_t v = bv(nm);
        v.mrdy = rdy; v.e_mv = 1'b1; v.e_maddr = ma;
        return v;
    endfunction

    function automatic vec_t fill_v(input logic [95:0] nm, input logic [1:0] way, input logic [8:0] da,
                                    input logic [31:0] d);
        vec_t v = bv(nm);
        v.rspv = 1'b1; v.rspd = d; v.e_dwe = way; v.e_daddr = da; v.e_dwd = d;
        return v;
    endfunction

    function automatic vec_t tag_v(input logic [95:0] nm, input logic [1:0] way, input logic [6:0] ti,
                                   input logic [31:0] te);
        vec_t v = bv(nm);
        v.e_twe = way; v.e_taddr = ti; v.e_twd = te; v.e_done = 1'b1;
        return v;
    endfunction

    function automatic vec_t inval_v(input logic [95:0] nm, input logic [1:0] way, input logic [6:0] ti);
        vec_t v = bv(nm);
        v.e_twe = way; v.e_taddr = ti; v.e_twd = 32'h0000_0000;
        return v;
    endfunction

    // full miss refill with hand-computed fetch address, data base address, tag index and entry
    task automatic push_refill(input logic [95:0] nm, input logic [31:0] a, input logic [1:0] wvld,
                               input logic [1:0] way, input logic [31:0] ma, input logic [8:0] dbase,
                               input logic [6:0] ti, input logic [31:0] te, input logic [31:0] d0,
                               input int gap);
        tbl.push_back(req_v(nm, a, 2'b11, wvld));
`ifdef CACHE_REFILL_TAG_INVAL_EN
        tbl.push_back(inval_v(nm, way, ti));
`endif
        tbl.push_back(mreq_v(nm, 1'b1, ma));
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) tbl.push_back(bv(nm));
            tbl.push_back(fill_v(nm, way, dbase + 9'(i), d0 + 32'(i)));
        end
        tbl.push_back(tag_v(nm, way, ti, te));
    endtask

    task automatic apply(input vec_t v);
        logic [119:0] act;
        logic [119:0] exp;
        @(negedge clk);
        rst                 = v.rst;
        bus.req_valid_i     = v.rv;
        bus.req_addr_i      = v.addr;
        bus.req_way_miss_i  = v.miss;
        bus.req_way_valid_i = v.wvld;
        bus.mem_req_ready_i = v.mrdy;
        bus.mem_rsp_valid_i = v.rspv;
        bus.mem_rsp_data_i  = v.rspd;
        #1;
        act = {bus.req_ready_o, bus.mem_req_valid_o, bus.mem_req_addr_o, bus.data_we_o, bus.data_addr_o,
               bus.data_wdata_o, bus.tag_we_o, bus.tag_addr_o, bus.tag_wdata_o, bus.busy_o, bus.done_o};
        exp = {v.e_rdy, v.e_mv, v.e_maddr, v.e_dwe, v.e_daddr, v.e_dwd, v.e_twe, v.e_taddr, v.e_twd,
               v.e_busy, v.e_done};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %0s: outputs %h, required %h", v.name, act, exp);
        end
    endtask

    task automatic drain();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        vec_t v;
        bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_way_miss_i = 2'b11; bus.req_way_valid_i = '0;
        bus.mem_req_ready_i = 1'b0; bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_data_i = '0;
        repeat (2) @(posedge clk);

        // ---------------- table-driven part ----------------
        v = nv("reset"); v.rst = 1'b1; tbl.push_back(v);
        tbl.push_back(nv("idle0"));
        // both ways invalid -> way 0
        push_refill("t1", 32'h1234, 2'b00, 2'b01, 32'h1234, 9'h034, 7'h0D, 32'h8000_0009, 32'hA0, 0);
        // both valid: rr=0 -> way0, then rr=1 -> way1
        push_refill("t2a", 32'h2468, 2'b11, 2'b01, 32'h2468, 9'h068, 7'h1A, 32'h8000_0012, 32'hB0, 0);
        push_refill("t2b", 32'hABCD, 2'b11, 2'b10, 32'hABCC, 9'h1CC, 7'h73, 32'h8000_0055, 32'hC0, 0);
        // way0 invalid -> way0 without advancing rr, so next all-valid miss still picks way0
        push_refill("t2c", 32'h1234, 2'b10, 2'b01, 32'h1234, 9'h034, 7'h0D, 32'h8000_0009, 32'hD0, 0);
        push_refill("t2d", 32'h2468, 2'b11, 2'b01, 32'h2468, 9'h068, 7'h1A, 32'h8000_0012, 32'hE0, 0);
        // stray response in IDLE must not write
        v = nv("t4_stray"); v.rspv = 1'b1; v.rspd = 32'hDEAD; tbl.push_back(v);
        // way1 invalid -> way1, responses every third cycle
        push_refill("t4_gap", 32'h0F00, 2'b01, 2'b10, 32'h0F00, 9'h100, 7'h40, 32'h8000_0007, 32'hF0, 2);
        // hit: no memory activity, done one cycle later, ready again after that
        tbl.push_back(req_v("t5_hit", 32'h1234, 2'b10, 2'b11));
        v = bv("t5_done"); v.e_done = 1'b1; tbl.push_back(v);
        tbl.push_back(nv("t5_idle"));
        drain();

        // ---------------- memory not ready for 5 cycles ----------------
        apply(req_v("t3_req", 32'hABCD, 2'b11, 2'b00));
`ifdef CACHE_REFILL_TAG_INVAL_EN
        apply(inval_v("t3_inval", 2'b01, 7'h73));
`endif
        for (int i = 0; i < 5; i++) begin
            v = mreq_v("t3_stall", 1'b0, 32'hABCC);
            v.rspv = 1'b1; v.rspd = 32'hBAD0;
            apply(v);
        end
        apply(mreq_v("t3_hs", 1'b1, 32'hABCC));
        for (int i = 0; i < 4; i++) apply(fill_v("t3_fill", 2'b01, 9'h1CC + 9'(i), 32'hC8 + 32'(i)));
        apply(tag_v("t3_tag", 2'b01, 7'h73, 32'h8000_0055));

        // ---------------- reset in the middle of FILL ----------------
        apply(req_v("t6_req", 32'h1234, 2'b11, 2'b00));
`ifdef CACHE_REFILL_TAG_INVAL_EN
        apply(inval_v("t6_inval", 2'b01, 7'h0D));
`endif
        apply(mreq_v("t6_mreq", 1'b1, 32'h1234));
        apply(fill_v("t6_w0", 2'b01, 9'h034, 32'h50));
        apply(fill_v("t6_w1", 2'b01, 9'h035, 32'h51));
        v = bv("t6_rst"); v.rst = 1'b1; apply(v);
        v = nv("t6_idle"); v.rspv = 1'b1; v.rspd = 32'hDEAD; apply(v);
        apply(nv("t6_idle2"));
        // counter and rr restart after reset: word 0 first, all-valid miss picks way0
        push_refill("t6_after", 32'h1234, 2'b11, 2'b01, 32'h1234, 9'h034, 7'h0D, 32'h8000_0009, 32'h60, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
